// File: rtl/pipelined_adder.sv
// pipelined_adder: N-bit add/sub split into STAGES carry slices with valid/ready flow control.
module pipelined_adder #(
  parameter int N = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         cin,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         ovf
);
  localparam int W = N / STAGES;
  logic [STAGES:0] v_q, v_d, c_q, c_d;
  logic [N-1:0] a_q [STAGES];
  logic [N-1:0] a_d [STAGES];
  logic [N-1:0] b_q [STAGES];
  logic [N-1:0] b_d [STAGES];
  logic [N-1:0] s_q [STAGES];
  logic [N-1:0] s_d [STAGES];
  logic ovf_q, ovf_d, advance;
  logic [W:0] sl;
  always_comb begin
    advance = !v_q[STAGES] || out_ready;
    v_d = v_q;
    c_d = c_q;
    a_d = a_q;
    b_d = b_q;
    s_d = s_q;
    ovf_d = ovf_q;
    sl = '0;
    if (advance) begin
      v_d = {v_q[STAGES-1:0], in_valid};
      c_d[0] = cin;
      a_d[0] = a;
      b_d[0] = sub ? ~b : b;
      // Operand ranks carry the full word; slice k only consumes its own bits.
      for (int k = 0; k < STAGES; k++) begin
        sl = {1'b0, a_q[k][k*W +: W]} + {1'b0, b_q[k][k*W +: W]} + {{W{1'b0}}, c_q[k]};
        s_d[k] = (k == 0) ? '0 : s_q[(k == 0) ? 0 : k - 1];
        s_d[k][k*W +: W] = sl[W-1:0];
        c_d[k+1] = sl[W];
      end
      for (int k = 1; k < STAGES; k++) begin
        a_d[k] = a_q[k-1];
        b_d[k] = b_q[k-1];
      end
      ovf_d = sl[W] ^ sl[W-1] ^ a_q[STAGES-1][N-1] ^ b_q[STAGES-1][N-1];
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      v_q <= '0;
      c_q <= '0;
      a_q <= '{default: '0};
      b_q <= '{default: '0};
      s_q <= '{default: '0};
      ovf_q <= 1'b0;
    end else begin
      v_q <= v_d;
      c_q <= c_d;
      a_q <= a_d;
      b_q <= b_d;
      s_q <= s_d;
      ovf_q <= ovf_d;
    end
  end
  assign in_ready = advance;
  assign out_valid = v_q[STAGES];
  assign sum = s_q[STAGES-1];
  assign cout = c_q[STAGES];
  assign ovf = ovf_q;
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: table vectors, directed flow-control sequences and random soak against a scoreboard.
module tb_pipelined_adder;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, in_ready, cin = 1'b0, sub = 1'b0;
  logic out_valid, out_ready = 1'b1, cout, ovf;
  logic [31:0] a = '0, b = '0, sum;
  typedef struct {logic [31:0] a, b; logic cin, sub; logic [31:0] s; logic co, ov;} vec_t;
  typedef struct {logic [31:0] s; logic co, ov; int cyc, st;} exp_t;
  vec_t tbl [9];
  exp_t exp_q [$];
  int errors = 0, checks = 0, cyc = 0, stalls = 0;
  logic held = 1'b0, h_co, h_ov, last_co, last_ov;
  logic [31:0] h_s, last_s;
  pipelined_adder #(.N(32), .STAGES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .cout(cout), .ovf(ovf)
  );
  always #5 clk = ~clk;
  function automatic logic [33:0] ref_model(input logic [31:0] x, y, input logic ci, sb);
    logic [31:0] yy;
    logic [32:0] r;
    yy = sb ? ~y : y;
    r = {1'b0, x} + {1'b0, yy} + 33'(ci);
    return {(x[31] == yy[31]) && (r[31] != x[31]), r};
  endfunction
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    logic [33:0] r;
    exp_t e;
    @(negedge clk);
    if (rst_n) begin
      check("in_ready_rule", in_ready, !out_valid || out_ready);
      if (held) begin
        check("hold_valid", out_valid, 1'b1);
        check("hold_sum", sum, h_s);
        check("hold_cout", cout, h_co);
        check("hold_ovf", ovf, h_ov);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          errors++;
          checks++;
          $display("FAIL unexpected_output: got sum %0h with no pending transaction", sum);
        end else begin
          e = exp_q.pop_front();
          check("sum", sum, e.s);
          check("cout", cout, e.co);
          check("ovf", ovf, e.ov);
          check("latency", cyc, e.cyc + 5 + stalls - e.st);
        end
        last_s = sum;
        last_co = cout;
        last_ov = ovf;
      end
      held = out_valid && !out_ready;
      if (held) begin
        h_s = sum;
        h_co = cout;
        h_ov = ovf;
        stalls++;
      end
      if (in_valid && in_ready) begin
        r = ref_model(a, b, cin, sub);
        exp_q.push_back('{r[31:0], r[32], r[33], cyc, stalls});
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    rst_n = 1'b1;
    exp_q.delete();
    held = 1'b0;
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_sum", sum, 32'h0);
    check("rst_cout", cout, 1'b0);
    check("rst_ovf", ovf, 1'b0);
  endtask
  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    while (exp_q.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    if (exp_q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask
  task automatic rand_ops();
    a = $urandom;
    b = $urandom;
    cin = 1'($urandom_range(0, 1));
    sub = 1'($urandom_range(0, 1));
  endtask
  initial begin
    tbl[0] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
    tbl[1] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
    tbl[2] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
    tbl[3] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
    tbl[4] = '{32'h00000007, 32'h00000005, 1'b1, 1'b1, 32'h00000002, 1'b1, 1'b0};
    tbl[5] = '{32'h00000007, 32'h00000005, 1'b0, 1'b1, 32'h00000001, 1'b1, 1'b0};
    tbl[6] = '{32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'h00000001, 1'b0, 1'b0};
    tbl[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
    tbl[8] = '{32'h00FF00FF, 32'h00010001, 1'b0, 1'b0, 32'h01000100, 1'b0, 1'b0};
    do_reset();
    foreach (tbl[i]) begin
      a = tbl[i].a;
      b = tbl[i].b;
      cin = tbl[i].cin;
      sub = tbl[i].sub;
      in_valid = 1'b1;
      tick();
      drain();
      check("tbl_sum", last_s, tbl[i].s);
      check("tbl_cout", last_co, tbl[i].co);
      check("tbl_ovf", last_ov, tbl[i].ov);
    end
    for (int i = 0; i < 8; i++) begin
      rand_ops();
      in_valid = 1'b1;
      check("stream_in_ready", in_ready, 1'b1);
      tick();
    end
    drain();
    out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      rand_ops();
      in_valid = 1'b1;
      if (i >= 5) check("bp_in_ready", in_ready, 1'b0);
      tick();
    end
    drain();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      rand_ops();
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    tick();
    do_reset();
    for (int i = 0; i < 6; i++) tick();
    a = 32'h12345678;
    b = 32'h0FEDCBA9;
    cin = 1'b0;
    sub = 1'b0;
    in_valid = 1'b1;
    tick();
    drain();
    check("post_rst_sum", last_s, 32'h22222221);
    for (int i = 0; i < 400; i++) begin
      rand_ops();
      in_valid = 1'($urandom_range(0, 1));
      out_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    drain();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipelined_adder.md
# pipelined_adder

Parametrised, pipelined N-bit adder/subtractor with a valid/ready stream interface. It is the sequential successor to the combinational adder set: the carry chain is cut into STAGES slices with one register per slice. This gives throughput of one operation per clock at a fixed latency, with backpressure support, so it can sit directly in a datapath stream.

## Interface
- N, default 32: operand/result width in bits.
- STAGES, default 4: pipeline depth and number of carry slices. N must be a multiple of STAGES; slice width is W = N/STAGES.
- clk  in  1  system clock, all state updates on rising edge.
- rst_n  in  1  synchronous active-low reset (one clock; reset is synchronous and active-low).
- in_valid  in  1  input transaction present.
- in_ready  out  1  block accepts input this cycle.
- a  in  N  operand A (unsigned or two's complement).
- b  in  N  operand B.
- cin  in  1  carry-in to bit 0.
- sub  in  1  1 = subtract mode: B is bitwise inverted before addition.
- out_valid  out  1  result present.
- out_ready  in  1  downstream accepts result.
- sum  out  N  result.
- cout  out  1  carry out of bit N-1.
- ovf  out  1  signed overflow: carry into bit N-1 XOR carry out of bit N-1.

## Operation
- Result: {cout, sum} = a + (sub ? ~b : b) + cin, computed modulo 2^(N+1).
  - cin is never forced. a − b requires sub=1, cin=1.
  - sub=1, cin=0 gives a − b − 1 (borrow chaining).
- Slice k (k = 0..STAGES-1) adds bits [k*W +: W] in pipeline stage k, using the carry registered by slice k-1 (slice 0 uses the cin captured with the transaction).
- Skew registers:
  - Operand slices k ≥ 1 are delayed k cycles so each meets its carry.
  - Result slices k < STAGES-1 are delayed (STAGES-1-k) cycles so all slices of one transaction leave together.
- ovf is derived in the last stage from the carry into and out of bit N-1.
- Each stage holds a valid bit. There are no partial or mixed transactions, and order is preserved (FIFO semantics).
- Flow control uses a single global advance enable: advance = !out_valid || out_ready.
  - in_ready = advance.
  - On advance, every stage shifts one position and stage 0 loads (in_valid && in_ready).
  - When advance = 0, all pipeline and skew registers hold.
- Bubbles are not squeezed: an empty inner stage stays empty while the output is stalled.
- STAGES = 1 degenerates to a registered full adder with latency 1.

## Timing
- Reset (rst_n=0 at a rising edge):
  - All stage valid bits clear; sum, cout and ovf become 0.
  - On the following cycle out_valid=0 and in_ready=1.
  - In-flight transactions are discarded, not emitted.
- Latency: a transaction accepted at edge T (in_valid && in_ready) drives out_valid=1 with its result after edge T+STAGES, provided no stall occurs in between. Each stalled cycle adds exactly one cycle.
- Throughput: 1 transaction/cycle while out_ready=1.
- Output is transferred on an edge where out_valid && out_ready.
- While out_valid=1 and out_ready=0, sum, cout and ovf are held stable.
- in_ready is combinational from out_valid and out_ready only. There is no combinational path from in_valid to any output.
- Simultaneous output transfer and input acceptance in the same cycle is legal and required at full rate.
- a, b, cin and sub are don't-care when in_valid=0. Bubble stages must not alter sum, cout or ovf of valid stages.

## Test plan
- Full-chain carry across all slice boundaries: N=32, STAGES=4, a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x00000000, cout=1, ovf=0, out_valid exactly 4 cycles after acceptance.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0, sub=0 -> sum=0x80000000, cout=0, ovf=1. Also a=0x80000000, b=0x80000000 -> sum=0, cout=1, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=1 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1, cin=1 -> sum=2, cout=1. Then a=7, b=5, sub=1, cin=0 -> sum=1.
- Streaming: 8 back-to-back random transactions with out_ready=1 -> 8 consecutive out_valid cycles starting at cycle 4, results match a reference model in order, and in_ready stays 1 throughout.
- Backpressure: fill the pipeline, hold out_ready=0 for 5 cycles -> in_ready=0, sum, cout and ovf stable and no new acceptance. Then release -> all queued results emerge in order with no loss or duplication.
- Reset mid-operation: 3 transactions in flight, rst_n=0 for one edge -> out_valid=0, sum=0, cout=0, ovf=0 next cycle, and none of the 3 results ever appear. A new transaction afterwards completes with latency 4.
